// File: rtl/mac_tx_arbiter_pkg.sv
// Shared MAC transmit parameters and the beat record carried through the arbiter's skid buffer.
package mac_params;
  localparam int N_SYMBOLS = 8;
  localparam int W_SYMBOL  = 8;
  localparam int N_REQ_MAX = 8;

  typedef struct packed {
    logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] data;
    logic [N_SYMBOLS-1:0]               keep;
    logic                               last;
  } axis_beat_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/mac_tx_arbiter_skid_buf.sv
// Two-entry AXI-Stream register slice: registered output and registered input ready,
// full throughput while the sink keeps accepting.
module axis_skid_buf
  import mac_params::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  axis_beat_t s_beat,
  output logic       s_ready,
  output logic       m_valid,
  output axis_beat_t m_beat,
  input  logic       m_ready
);

  axis_beat_t spare, spare_n, m_beat_n;
  logic       spare_valid, spare_valid_n, m_valid_n;
  logic       push, load_out;

  assign push     = s_valid & s_ready;
  assign load_out = ~m_valid | m_ready;

  // The output slot only changes when it is empty or being consumed; the spare
  // entry absorbs the beat that arrives while the sink stalls.
  always_comb begin
    m_valid_n     = m_valid;
    m_beat_n      = m_beat;
    spare_n       = spare;
    spare_valid_n = spare_valid;
    if (load_out) begin
      if (spare_valid) begin
        m_valid_n     = 1'b1;
        m_beat_n      = spare;
        spare_valid_n = push;
        if (push) spare_n = s_beat;
      end else begin
        m_valid_n = push;
        if (push) m_beat_n = s_beat;
      end
    end else if (push) begin
      spare_valid_n = 1'b1;
      spare_n       = s_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid     <= 1'b0;
      m_beat      <= '0;
      spare       <= '0;
      spare_valid <= 1'b0;
      s_ready     <= 1'b1;
    end else begin
      m_valid     <= m_valid_n;
      m_beat      <= m_beat_n;
      spare       <= spare_n;
      spare_valid <= spare_valid_n;
      s_ready     <= ~(m_valid_n & spare_valid_n);
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic round-robin arbiter feeding the MAC transmit stream from N_REQ sources.
//   state    | meaning
//   ARB_IDLE | no owner; pick next valid requester after last_ptr
//   ARB_BUSY | owner last_ptr streams until its tlast beat is accepted
module mac_tx_arbiter
  import mac_params::*;
#(
  parameter int N_REQ = 4,
  parameter int W_CNT = 16
) (
  input  logic                                          i_tx_clk,
  input  logic                                          i_tx_reset,
  input  logic [N_REQ-1:0]                              s_axis_tvalid,
  input  logic [N_REQ-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0][N_SYMBOLS-1:0]               s_axis_tkeep,
  input  logic [N_REQ-1:0]                              s_axis_tlast,
  output logic [N_REQ-1:0]                              s_axis_tready,
  output logic                                          m_axis_tvalid,
  output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]            m_axis_tdata,
  output logic [N_SYMBOLS-1:0]                          m_axis_tkeep,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  output logic [N_REQ-1:0]                              o_grant,
  output logic [N_REQ-1:0][W_CNT-1:0]                   o_frame_cnt
);

  localparam int W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state, state_n;
  logic [W_PTR-1:0] last_ptr, last_ptr_n, pick, cand;
  logic [N_REQ-1:0] grant_n;
  logic             pick_found;
  logic             skid_ready, in_valid, accept, accept_last;
  axis_beat_t       in_beat, out_beat;
  int               idx;

  assign in_valid      = (state == ARB_BUSY) && s_axis_tvalid[last_ptr];
  assign accept        = in_valid & skid_ready;
  assign accept_last   = accept & s_axis_tlast[last_ptr];
  assign s_axis_tready = (state == ARB_BUSY) ? (o_grant & {N_REQ{skid_ready}}) : '0;
  assign in_beat       = '{data: s_axis_tdata[last_ptr],
                           keep: s_axis_tkeep[last_ptr],
                           last: s_axis_tlast[last_ptr]};

  // Scan starts one past the previous winner so every source gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    idx        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last_ptr) + k) % N_REQ;
      cand = W_PTR'(idx);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = o_grant;
    last_ptr_n = last_ptr;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_n    = ARB_BUSY;
          last_ptr_n = pick;
          grant_n    = N_REQ'(1) << pick;
        end
      end
      ARB_BUSY: begin
        if (accept_last) begin
          state_n = ARB_IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge i_tx_clk) begin
    if (i_tx_reset) begin
      state       <= ARB_IDLE;
      o_grant     <= '0;
      last_ptr    <= W_PTR'(N_REQ - 1);
      o_frame_cnt <= '0;
    end else begin
      state    <= state_n;
      o_grant  <= grant_n;
      last_ptr <= last_ptr_n;
      if (accept_last) o_frame_cnt[last_ptr] <= o_frame_cnt[last_ptr] + W_CNT'(1);
    end
  end

  axis_skid_buf u_skid (
    .clk     (i_tx_clk),
    .reset   (i_tx_reset),
    .s_valid (in_valid),
    .s_beat  (in_beat),
    .s_ready (skid_ready),
    .m_valid (m_axis_tvalid),
    .m_beat  (out_beat),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tkeep = out_beat.keep;
  assign m_axis_tlast = out_beat.last;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: per-requester frame sources, a beat scoreboard on the MAC side,
// a table of arbitration vectors and hand-written multi-cycle sequences.
module tb_mac_tx_arbiter;
  import mac_params::*;

  localparam int NR = 4;
  localparam int WC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                       i_tx_reset;
  logic [NR-1:0]                              s_axis_tvalid;
  logic [NR-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0] s_axis_tdata;
  logic [NR-1:0][N_SYMBOLS-1:0]               s_axis_tkeep;
  logic [NR-1:0]                              s_axis_tlast;
  logic [NR-1:0]                              s_axis_tready;
  logic                                       m_axis_tvalid;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]         m_axis_tdata;
  logic [N_SYMBOLS-1:0]                       m_axis_tkeep;
  logic                                       m_axis_tlast;
  logic                                       m_axis_tready;
  logic [NR-1:0]                              o_grant;
  logic [NR-1:0][WC-1:0]                      o_frame_cnt;

  mac_tx_arbiter #(.N_REQ(NR), .W_CNT(WC)) dut (
    .i_tx_clk      (clk),
    .i_tx_reset    (i_tx_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_grant       (o_grant),
    .o_frame_cnt   (o_frame_cnt)
  );

  typedef struct { logic [NR-1:0] mask; logic [NR-1:0] exp_grant; } arb_vec_t;
  typedef struct { int idx; int cyc; } grant_ev_t;

  axis_beat_t src_q[NR][$];
  axis_beat_t exp_q[$];
  grant_ev_t  glog[$];
  arb_vec_t   tbl[10];

  logic [NR-1:0] hold = '0;
  logic [NR-1:0] acc = '0;
  logic [NR-1:0] prev_grant = '0;
  logic          prev_stall = 1'b0;
  logic          prev_valid = 1'b0;
  axis_beat_t    prev_beat;
  logic          bp_en = 1'b0;
  int            bp_phase = 0;
  int            cyc = 0;
  int            rx_cnt = 0;
  int            frame_tag = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int r, input int nb);
    axis_beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data = {8'(r), 8'(k), 16'(frame_tag), 32'($urandom)};
      b.keep = 8'($urandom_range(1, 255));
      b.last = (k == nb - 1);
      src_q[r].push_back(b);
    end
    frame_tag++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i]  = src_q[i][0].data;
        s_axis_tkeep[i]  = src_q[i][0].keep;
        s_axis_tlast[i]  = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i]  = '0;
        s_axis_tkeep[i]  = '0;
        s_axis_tlast[i]  = 1'b0;
      end
    end
    m_axis_tready = bp_en ? ((bp_phase % 4 == 0) || (bp_phase % 4 == 3)) : 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    bp_phase++;
    drive();
  endtask

  function automatic logic is_drained();
    logic d;
    d = (exp_q.size() == 0) && (o_grant == '0) && !m_axis_tvalid;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_drained(input string name, input int limit);
    int c;
    c = 0;
    while (!is_drained() && c < limit) begin
      step();
      c++;
    end
    chk({name, "_done"}, 64'(is_drained()), 64'd1);
  endtask

  task automatic do_reset();
    i_tx_reset = 1'b1;
    hold       = '0;
    bp_en      = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive();
    repeat (3) step();
    i_tx_reset = 1'b0;
    glog.delete();
    rx_cnt = 0;
    drive();
  endtask

  // MAC-side monitor: records accepted source beats, checks every MAC beat in order,
  // checks stall stability and logs each new grant.
  always @(negedge clk) begin
    axis_beat_t e;
    cyc++;
    if (i_tx_reset) begin
      acc = '0;
      exp_q.delete();
      prev_stall = 1'b0;
      prev_grant = '0;
    end else begin
      acc = s_axis_tvalid & s_axis_tready;
      for (int i = 0; i < NR; i++) if (acc[i]) exp_q.push_back(src_q[i][0]);
      chk("ready_onehot", 64'($onehot0(s_axis_tready)), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'(prev_valid));
        chk("stall_data", m_axis_tdata, prev_beat.data);
        chk("stall_keep", 64'(m_axis_tkeep), 64'(prev_beat.keep));
        chk("stall_last", 64'(m_axis_tlast), 64'(prev_beat.last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e.data);
          chk("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
          chk("out_last", 64'(m_axis_tlast), 64'(e.last));
          rx_cnt++;
        end
      end
      prev_stall     = m_axis_tvalid & !m_axis_tready;
      prev_valid     = m_axis_tvalid;
      prev_beat.data = m_axis_tdata;
      prev_beat.keep = m_axis_tkeep;
      prev_beat.last = m_axis_tlast;
      if (o_grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < NR; i++) if (o_grant[i]) glog.push_back('{idx: i, cyc: cyc});
      end
      prev_grant = o_grant;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    i_tx_reset    = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;

    // last winner after reset is 3, so the first scan order is 0,1,2,3
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0001, 4'b0001};
    tbl[3] = '{4'b1100, 4'b0100};
    tbl[4] = '{4'b1001, 4'b1000};
    tbl[5] = '{4'b1001, 4'b0001};
    tbl[6] = '{4'b0110, 4'b0010};
    tbl[7] = '{4'b0100, 4'b0100};
    tbl[8] = '{4'b0011, 4'b0001};
    tbl[9] = '{4'b1000, 4'b1000};

    // reset state
    do_reset();
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_ready", 64'(s_axis_tready), 64'd0);
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    for (int i = 0; i < NR; i++) chk($sformatf("rst_cnt%0d", i), 64'(o_frame_cnt[i]), 64'd0);
    step();
    chk("idle_grant", 64'(o_grant), 64'd0);

    // arbitration table: one-beat frames, losers withdraw after the grant
    for (int e = 0; e < 10; e++) begin
      for (int i = 0; i < NR; i++) if (tbl[e].mask[i]) push_frame(i, 1);
      drive();
      step();
      chk($sformatf("arb%0d_grant", e), 64'(o_grant), 64'(tbl[e].exp_grant));
      chk($sformatf("arb%0d_ready", e), 64'(s_axis_tready), 64'(tbl[e].exp_grant));
      for (int i = 0; i < NR; i++) if (!tbl[e].exp_grant[i]) src_q[i].delete();
      drive();
      step();
      chk($sformatf("arb%0d_mvalid", e), 64'(m_axis_tvalid), 64'd1);
      chk($sformatf("arb%0d_release", e), 64'(o_grant), 64'd0);
      run_until_drained($sformatf("arb%0d", e), 20);
    end
    chk("tbl_cnt0", 64'(o_frame_cnt[0]), 64'd4);
    chk("tbl_cnt1", 64'(o_frame_cnt[1]), 64'd2);
    chk("tbl_cnt2", 64'(o_frame_cnt[2]), 64'd2);
    chk("tbl_cnt3", 64'(o_frame_cnt[3]), 64'd2);

    // round robin with continuous 3-beat frames
    do_reset();
    for (int f = 0; f < 2; f++) for (int r = 0; r < NR; r++) push_frame(r, 3);
    drive();
    run_until_drained("rr", 100);
    chk("rr_grants", 64'(glog.size()), 64'd8);
    for (int j = 0; j < glog.size() && j < 8; j++) begin
      chk($sformatf("rr_order%0d", j), 64'(glog[j].idx), 64'(j % 4));
      if (j > 0) chk($sformatf("rr_period%0d", j), 64'(glog[j].cyc - glog[j-1].cyc), 64'd4);
    end
    for (int i = 0; i < NR; i++) chk($sformatf("rr_cnt%0d", i), 64'(o_frame_cnt[i]), 64'd2);

    // backpressure 1,0,0,1 on a 10-beat frame from requester 2
    do_reset();
    bp_en    = 1'b1;
    bp_phase = 0;
    push_frame(2, 10);
    drive();
    run_until_drained("bp", 100);
    bp_en = 1'b0;
    chk("bp_rx", 64'(rx_cnt), 64'd10);
    chk("bp_cnt2", 64'(o_frame_cnt[2]), 64'd1);
    chk("bp_owner", 64'((glog.size() > 0) ? glog[0].idx : -1), 64'd2);

    // frame atomicity: requester 1 pauses mid-frame while 3 waits
    do_reset();
    push_frame(1, 8);
    push_frame(3, 2);
    drive();
    c = 0;
    while (src_q[1].size() > 6 && c < 20) begin step(); c++; end
    chk("atom_start", 64'(src_q[1].size()), 64'd6);
    hold[1] = 1'b1;
    drive();
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("atom_hold_grant%0d", j), 64'(o_grant), 64'b0010);
      chk($sformatf("atom_hold_rdy3_%0d", j), 64'(s_axis_tready[3]), 64'd0);
    end
    hold[1] = 1'b0;
    drive();
    run_until_drained("atom", 60);
    chk("atom_grants", 64'(glog.size()), 64'd2);
    if (glog.size() >= 2) begin
      chk("atom_first", 64'(glog[0].idx), 64'd1);
      chk("atom_second", 64'(glog[1].idx), 64'd3);
    end
    chk("atom_cnt1", 64'(o_frame_cnt[1]), 64'd1);
    chk("atom_cnt3", 64'(o_frame_cnt[3]), 64'd1);

    // reset on beat 4 of an 8-beat frame
    do_reset();
    push_frame(2, 3);
    drive();
    run_until_drained("mr_pre", 20);
    chk("mr_pre_cnt2", 64'(o_frame_cnt[2]), 64'd1);
    push_frame(2, 8);
    drive();
    c = 0;
    while (src_q[2].size() > 5 && c < 20) begin step(); c++; end
    chk("mr_beat4", 64'(src_q[2].size()), 64'd5);
    i_tx_reset = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive();
    step();
    chk("mr_grant", 64'(o_grant), 64'd0);
    chk("mr_ready", 64'(s_axis_tready), 64'd0);
    chk("mr_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mr_mdata", m_axis_tdata, 64'd0);
    chk("mr_mkeep", 64'(m_axis_tkeep), 64'd0);
    chk("mr_mlast", 64'(m_axis_tlast), 64'd0);
    for (int i = 0; i < NR; i++) chk($sformatf("mr_cnt%0d", i), 64'(o_frame_cnt[i]), 64'd0);
    i_tx_reset = 1'b0;
    glog.delete();
    push_frame(2, 1);
    push_frame(0, 1);
    push_frame(3, 1);
    drive();
    step();
    chk("mr_first_grant", 64'(o_grant), 64'b0001);
    run_until_drained("mr_post", 40);
    chk("mr_post_cnt0", 64'(o_frame_cnt[0]), 64'd1);
    chk("mr_post_cnt2", 64'(o_frame_cnt[2]), 64'd1);
    chk("mr_post_cnt3", 64'(o_frame_cnt[3]), 64'd1);

    // 4-bit counter wraps after 16 frames
    do_reset();
    for (int f = 0; f < 17; f++) push_frame(0, 1);
    drive();
    run_until_drained("wrap", 200);
    chk("wrap_cnt0", 64'(o_frame_cnt[0]), 64'd1);
    chk("wrap_cnt1", 64'(o_frame_cnt[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
